pipe_stage_reg: RTL and testbench

Parametrised successor to the fixed ID/EX latch: one generic pipeline-stage register for any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data bundle and a control bundle with valid/ready handshake, global hold (hit), flush-to-bubble, and an optional 2-entry skid buffer.
- Sits between two pipeline stages. Upstream drives the in_* side; downstream consumes out_*.

---
 rtl/pipe_stage_reg_pkg.sv | 41 ++++
 rtl/pipe_stage_entry.sv | 44 ++++
 rtl/pipe_stage_reg.sv | 160 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for generic pipeline-stage registers: skid-state encoding,
// per-boundary bundle widths and control-bundle bit offsets.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  // Bundle widths per stage boundary
  localparam int IF_ID_DATA_W  = 64;
  localparam int IF_ID_CTRL_W  = 1;
  localparam int ID_EX_DATA_W  = 96;
  localparam int ID_EX_CTRL_W  = 12;
  localparam int EX_MEM_DATA_W = 101;
  localparam int EX_MEM_CTRL_W = 6;
  localparam int MEM_WB_DATA_W = 69;
  localparam int MEM_WB_CTRL_W = 2;

  // Control-bundle field offsets (ID/EX layout)
  localparam int CTRL_REG_WRITE   = 0;
  localparam int CTRL_MEM_READ    = 1;
  localparam int CTRL_MEM_WRITE   = 2;
  localparam int CTRL_BRANCH      = 3;
  localparam int CTRL_ALU_OP_LSB  = 4;
  localparam int CTRL_ALU_OP_W    = 4;
  localparam int CTRL_MEM_TO_REG  = 8;
  localparam int CTRL_ALU_SRC     = 9;
  localparam int CTRL_JUMP        = 10;
  localparam int CTRL_LINK        = 11;

  function automatic logic [1:0] occ_of_state(input stage_state_e s);
    case (s)
      ST_BUSY: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One valid+ctrl+data holding register. Clear kills the entry (ctrl forced to 0,
// data left as is); load captures a new bundle. Updates on the falling clock edge.
module pipe_stage_entry
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = ID_EX_DATA_W,
  parameter int                CTRL_W     = ID_EX_CTRL_W,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= RESET_DATA;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready, global hold, flush-to-bubble.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid build with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = ID_EX_DATA_W,
  parameter int                CTRL_W     = ID_EX_CTRL_W,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hit,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              w_accept;
  logic              w_drain;
  logic              w_main_load;
  logic              w_main_clear;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_main_ctrl;

  assign w_accept = in_valid & in_ready & hit & ~flush;
  assign w_drain  = out_valid & out_ready & hit;

  pipe_stage_entry #(
    .DATA_W     (DATA_W),
    .CTRL_W     (CTRL_W),
    .RESET_DATA (RESET_DATA)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_data),
    .i_ctrl  (w_main_ctrl),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_ctrl  (out_ctrl)
  );

`ifdef PIPE_STAGE_SKID_EN

  stage_state_e      r_state;
  stage_state_e      w_state_next;
  logic              r_in_ready;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_skid_ctrl;

  pipe_stage_entry #(
    .DATA_W     (DATA_W),
    .CTRL_W     (CTRL_W),
    .RESET_DATA (RESET_DATA)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (in_data),
    .i_ctrl  (in_ctrl),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .o_ctrl  (w_skid_ctrl)
  );

  always_comb begin
    w_state_next = r_state;
    w_main_load  = 1'b0;
    w_main_clear = 1'b0;
    w_main_data  = in_data;
    w_main_ctrl  = in_ctrl;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    if (flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_main_load  = 1'b1;
            w_state_next = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_accept && w_drain) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_skid_load  = 1'b1;
            w_state_next = ST_FULL;
          end else if (w_drain) begin
            w_main_clear = 1'b1;
            w_state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Skid bundle is older than anything upstream, so it refills main first
          if (w_drain) begin
            w_main_load  = 1'b1;
            w_main_data  = w_skid_data;
            w_main_ctrl  = w_skid_ctrl;
            w_skid_clear = 1'b1;
            w_state_next = ST_BUSY;
          end
        end
        default: begin
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
          w_state_next = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != ST_FULL);
    end
  end

  assign in_ready  = r_in_ready;
  assign occupancy = occ_of_state(r_state) & {1'b1, ~w_skid_valid | out_valid};

`else

  logic r_started;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) r_started <= 1'b0;
    else        r_started <= 1'b1;
  end

  assign w_main_load  = w_accept;
  assign w_main_clear = flush | (w_drain & ~w_accept);
  assign w_main_data  = in_data;
  assign w_main_ctrl  = in_ctrl;

  assign in_ready  = r_started & (~out_valid | out_ready);
  assign occupancy = {1'b0, out_valid};

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: FIFO-queue reference model plus directed
// scenarios; honours PIPE_STAGE_SKID_EN to pick the 1- or 2-entry model.
module tb_pipe_stage_reg;

  localparam int DW = 96;
  localparam int CW = 12;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          hit       = 1'b0;
  logic          flush     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic [CW-1:0] in_ctrl   = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W     (DW),
    .CTRL_W     (CW),
    .RESET_DATA ('0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hit       (hit),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of held bundles, oldest at the front
  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } bundle_t;

  bundle_t q[$];
  bit      started = 0;

  function automatic bit exp_ready();
    if (!started) return 1'b0;
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  always @(negedge clk or negedge rst_n) begin
    bit      acc;
    bit      drn;
    bundle_t b;
    if (!rst_n) begin
      q.delete();
      started = 0;
    end else begin
      acc = in_valid && exp_ready() && hit && !flush;
      drn = hit && (q.size() > 0) && out_ready;
      started = 1;
      if (flush) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) begin
          b.d = in_data;
          b.c = in_ctrl;
          q.push_back(b);
        end
      end
    end
  end

  // Per-cycle compare, sampled mid-period away from the falling edge
  always @(posedge clk) begin
    chk("in_ready", 128'(in_ready), 128'(exp_ready()));
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    chk("occupancy", 128'(occupancy), 128'(q.size()));
    if (q.size() > 0) begin
      chk("out_data", 128'(out_data), 128'(q[0].d));
      chk("out_ctrl", 128'(out_ctrl), 128'(q[0].c));
    end else begin
      chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit h, input bit f, input bit iv, input bit ordy,
                       input logic [DW-1:0] d, input logic [CW-1:0] c);
    hit = h; flush = f; in_valid = iv; out_ready = ordy; in_data = d; in_ctrl = c;
  endtask

  initial begin
    // Reset
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_occupancy", 128'(occupancy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    cyc();
    cyc();
    rst_n = 1'b1;
    drive(1, 0, 0, 1, '0, '0);
    cyc();
    chk("in_ready_after_release", 128'(in_ready), 128'(1));

    // Streaming 1..8
    for (int k = 1; k <= 8; k++) begin
      drive(1, 0, 1, 1, DW'(k), CW'(k));
      cyc();
      chk("stream_data", 128'(out_data), 128'(k));
      chk("stream_in_ready", 128'(in_ready), 128'(1));
    end
    drive(1, 0, 0, 1, '0, '0);
    cyc();
    chk("stream_drained", 128'(out_valid), 128'(0));

    // Hold with hit=0
    drive(1, 0, 1, 0, DW'(32'hABC), CW'(12'h5A5));
    cyc();
    drive(0, 0, 1, 1, DW'(32'h777), CW'(12'h1));
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("hold_data", 128'(out_data), 128'(32'hABC));
      chk("hold_occ", 128'(occupancy), 128'(1));
    end
    drive(1, 0, 0, 1, '0, '0);
    cyc();
    chk("hold_drained", 128'(out_valid), 128'(0));

`ifdef PIPE_STAGE_SKID_EN
    // Back-pressure into the skid entry
    drive(1, 0, 1, 0, DW'(32'hA), CW'(12'h00A));
    cyc();
    drive(1, 0, 1, 0, DW'(32'hB), CW'(12'h00B));
    cyc();
    chk("bp_occ", 128'(occupancy), 128'(2));
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    chk("bp_data_a", 128'(out_data), 128'(32'hA));
    drive(1, 0, 1, 1, DW'(32'hC), CW'(12'h00C));
    cyc();
    chk("bp_data_b", 128'(out_data), 128'(32'hB));
    chk("bp_ready_up", 128'(in_ready), 128'(1));
    cyc();
    chk("bp_data_c", 128'(out_data), 128'(32'hC));
    drive(1, 0, 0, 1, '0, '0);
    cyc();
    chk("bp_drained", 128'(out_valid), 128'(0));
`endif

    // Flush from full occupancy, bundle on the flush edge is dropped
    drive(1, 0, 1, 0, DW'(32'h11), CW'(12'h011));
    cyc();
    drive(1, 0, 1, 0, DW'(32'h22), CW'(12'h022));
    cyc();
    chk("flush_pre_occ", 128'(occupancy), 128'(CAP));
    drive(1, 1, 1, 0, DW'(32'h55), CW'(12'hFFF));
    cyc();
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_ctrl", 128'(out_ctrl), 128'(0));
    chk("flush_occ", 128'(occupancy), 128'(0));
    drive(1, 0, 0, 1, '0, '0);
    cyc();
    chk("flush_no_55", 128'(out_valid), 128'(0));

    // Flush beats hit=0
    drive(1, 0, 1, 0, DW'(32'h66), CW'(12'h066));
    cyc();
    chk("fh_loaded", 128'(out_valid), 128'(1));
    drive(0, 1, 0, 0, '0, '0);
    cyc();
    chk("fh_valid", 128'(out_valid), 128'(0));
    chk("fh_occ", 128'(occupancy), 128'(0));

    // Asynchronous reset mid-transfer
    drive(1, 0, 1, 0, DW'(32'h1234), CW'(12'hFFF));
    cyc();
    chk("mr_ctrl_live", 128'(out_ctrl), 128'(12'hFFF));
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 128'(out_valid), 128'(0));
    chk("mr_ctrl", 128'(out_ctrl), 128'(0));
    chk("mr_data", 128'(out_data), 128'(0));
    chk("mr_occ", 128'(occupancy), 128'(0));
    cyc();
    rst_n = 1'b1;
    drive(1, 0, 0, 1, '0, '0);
    cyc();

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            {$urandom, $urandom, $urandom}, CW'($urandom));
      cyc();
    end

    drive(1, 0, 0, 1, '0, '0);
    cyc();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
